mem_arbiter: RTL

Arbitrates the single RAM port between the instruction-fetch requester (I-side) and the data-access requester (D-side) of the pipelined MIPS core. It produces the `ihit` that gates the IF/ID latch and the `dhit` that gates the MEM stage. A small FSM owns the RAM port for one transaction at a time. Data is favoured, with a bounded-starvation guarantee for fetch and a per-transaction timeout.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-RAM-port arbiter between I-fetch and D-access; D favoured, I guaranteed service after
// STARVE_MAX consecutive D grants, and any grant aborted after TIMEOUT cycles without ack.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        ram_ack,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        timeout_err
);

  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);
  localparam logic [7:0]    TLIM       = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic [7:0]    tcnt_q, tcnt_d;

  logic d_req;
  logic expired;

  assign d_req   = dREN | dWEN;
  assign expired = (tcnt_q == TLIM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      tcnt_q    <= tcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dstreak_d   = dstreak_q;
    tcnt_d      = tcnt_q;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'h0;
    ramstore    = 32'h0;
    ihit        = 1'b0;
    dhit        = 1'b0;
    iload       = 32'h0;
    dload       = 32'h0;
    timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        tcnt_d = 8'h0;
        // Streak only counts D wins taken while I was waiting; it stops growing at the limit.
        if (d_req && (!iREN || dstreak_q < STARVE_LIM)) begin
          state_d = DGRANT;
          if (iREN) dstreak_d = dstreak_q + STREAK_ONE;
        end else if (iREN) begin
          state_d   = IGRANT;
          dstreak_d = '0;
        end
      end
      IGRANT: begin
        ramREN      = iREN;
        ramaddr     = iaddr;
        iload       = ramload;
        ihit        = iREN & ram_ack & ~expired;
        timeout_err = iREN & expired;
        if (!iREN || ram_ack || expired) state_d = IDLE;
        else                             tcnt_d  = tcnt_q + 8'd1;
      end
      DGRANT: begin
        ramREN      = dREN;
        ramWEN      = dWEN;
        ramaddr     = daddr;
        ramstore    = dstore;
        dload       = ramload;
        dhit        = d_req & ram_ack & ~expired;
        timeout_err = d_req & expired;
        if (!d_req || ram_ack || expired) state_d = IDLE;
        else                              tcnt_d  = tcnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    if (!iREN) dstreak_d = '0;

    // Reset silences the port in the same cycle so an in-flight ack never produces a hit.
    if (RST) begin
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = 32'h0;
      ramstore    = 32'h0;
      ihit        = 1'b0;
      dhit        = 1'b0;
      iload       = 32'h0;
      dload       = 32'h0;
      timeout_err = 1'b0;
    end
  end

endmodule
